fhe_op_scheduler: RTL and testbench

- Command queue and sequencer between the Wishbone opcode register (0x3000_0000) and the FHE compute core (encrypt/decrypt/add/multiply).
- Buffers opcode words so the host can post several back-to-back operations.
- Issues one operation at a time to the core and waits for completion.
- Tracks retired operations, raises a drain interrupt, and records sticky errors (overflow, invalid command, core timeout).

---
 rtl/fhe_pkg.sv | 30 +++
 rtl/fhe_cmd_fifo.sv | 50 +++++
 rtl/fhe_op_scheduler.sv | 146 ++++++++++++++
 tb/tb_fhe_op_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fhe_pkg.sv
// rtl/fhe_pkg.sv - shared encodings for the FHE operation scheduler
// Purpose: opcode word layout, op encodings, scheduler FSM states and
//          error bit indices used by fhe_op_scheduler and its bench.
// Ports:   none (package).
package fhe_pkg;

  localparam logic [1:0] OP_ENC = 2'b00;
  localparam logic [1:0] OP_DEC = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  // Opcode word field positions
  localparam int OPCODE_OP_LSB    = 0;
  localparam int OPCODE_OP_W      = 2;
  localparam int OPCODE_SRC0_LSB  = 2;
  localparam int OPCODE_SRC1_LSB  = 11;
  localparam int OPCODE_DST_LSB   = 20;
  localparam int OPCODE_VALID_BIT = 31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } sched_state_t;

  localparam int ERR_OVERFLOW = 0;
  localparam int ERR_INVALID  = 1;
  localparam int ERR_TIMEOUT  = 2;

endpackage

// File: rtl/fhe_cmd_fifo.sv
// rtl/fhe_cmd_fifo.sv - synchronous command FIFO for the FHE scheduler
// Purpose: holds posted opcode words until the sequencer pops them.
// Ports:   clk, rst_n (async active-low); push/wdata write side;
//          pop/rdata read side (rdata is the current head, show-ahead);
//          full, empty, count status.
module fhe_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [PW:0]      wptr;
  logic [PW:0]      rptr;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (PW+1)'(1);
      if (pop)  rptr <= rptr + (PW+1)'(1);
    end
  end

  // A push into a full FIFO is only issued alongside a pop; the head is
  // read before the slot is overwritten at the same edge.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[PW-1:0]] <= wdata;
  end

  assign rdata = mem[rptr[PW-1:0]];
  assign count = wptr - rptr;
  assign full  = (count == FULL_CNT);
  assign empty = (wptr == rptr);

endmodule

// File: rtl/fhe_op_scheduler.sv
// rtl/fhe_op_scheduler.sv - command queue and sequencer for the FHE core
// Purpose: buffers opcode words written by the host, issues them one at a
//          time to the compute core, waits for completion or timeout,
//          counts retired ops, raises a drain interrupt and sticky errors.
// Ports:   wb_clk_i, wb_rst_n (async active-low);
//          cmd_wr_i/cmd_data_i/cmd_ready_o host command write side;
//          op_start_o, op_code_o, op_src0_o, op_src1_o, op_dst_o,
//          op_done_i, op_abort_o core handshake;
//          busy_o, queue_count_o, retired_count_o, err_o, err_clr_i,
//          irq_o status and interrupt.
module fhe_op_scheduler
  import fhe_pkg::*;
#(
  parameter int ADDR_WIDTH     = 9,
  parameter int QUEUE_DEPTH    = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_n,
  input  logic                         cmd_wr_i,
  input  logic [31:0]                  cmd_data_i,
  output logic                         cmd_ready_o,
  output logic                         op_start_o,
  output logic [1:0]                   op_code_o,
  output logic [ADDR_WIDTH-1:0]        op_src0_o,
  output logic [ADDR_WIDTH-1:0]        op_src1_o,
  output logic [ADDR_WIDTH-1:0]        op_dst_o,
  input  logic                         op_done_i,
  output logic                         op_abort_o,
  output logic                         busy_o,
  output logic [$clog2(QUEUE_DEPTH):0] queue_count_o,
  output logic [CNT_WIDTH-1:0]         retired_count_o,
  output logic [2:0]                   err_o,
  input  logic                         err_clr_i,
  output logic                         irq_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  sched_state_t state, state_nxt;
  logic [TW-1:0] tcnt;

  logic        fifo_full, fifo_empty;
  logic [31:0] fifo_rdata;
  logic        push, pop;
  logic        word_valid, done_evt, timeout_hit;
  logic [2:0]  err_new;
  logic        unused_bits;

  assign word_valid = cmd_data_i[OPCODE_VALID_BIT];

  // Pop decision uses the registered FIFO state, so an empty queue never
  // sees a same-cycle push and pop.
  assign pop  = (state == ST_IDLE) && !fifo_empty;
  assign push = cmd_wr_i && word_valid && (!fifo_full || pop);

  // Completion is accepted in ISSUE as well as WAIT.
  assign done_evt    = ((state == ST_ISSUE) || (state == ST_WAIT)) && op_done_i;
  assign timeout_hit = (state == ST_WAIT) && !op_done_i && (tcnt == TMO_LAST);

  always_comb begin
    err_new               = '0;
    err_new[ERR_OVERFLOW] = cmd_wr_i && word_valid && fifo_full && !pop;
    err_new[ERR_INVALID]  = cmd_wr_i && !word_valid;
    err_new[ERR_TIMEOUT]  = timeout_hit;
  end

  fhe_cmd_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n),
    .push  (push),
    .wdata (cmd_data_i),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (queue_count_o)
  );

  assign unused_bits = ^fifo_rdata[31:29];

  always_comb begin
    state_nxt  = state;
    op_start_o = 1'b0;
    op_abort_o = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pop) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        op_start_o = 1'b1;
        state_nxt  = op_done_i ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        if (op_done_i) begin
          state_nxt = ST_IDLE;
        end else if (timeout_hit) begin
          op_abort_o = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state           <= ST_IDLE;
      tcnt            <= '0;
      op_code_o       <= '0;
      op_src0_o       <= '0;
      op_src1_o       <= '0;
      op_dst_o        <= '0;
      retired_count_o <= '0;
      err_o           <= '0;
      irq_o           <= 1'b0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        op_code_o <= fifo_rdata[OPCODE_OP_LSB +: OPCODE_OP_W];
        op_src0_o <= fifo_rdata[OPCODE_SRC0_LSB +: ADDR_WIDTH];
        op_src1_o <= fifo_rdata[OPCODE_SRC1_LSB +: ADDR_WIDTH];
        op_dst_o  <= fifo_rdata[OPCODE_DST_LSB +: ADDR_WIDTH];
      end
      if (state == ST_ISSUE) begin
        tcnt <= '0;
      end else if ((state == ST_WAIT) && !op_done_i) begin
        tcnt <= tcnt + TW'(1);
      end
      if (done_evt) retired_count_o <= retired_count_o + CNT_WIDTH'(1);
      // Drain interrupt: the op just retired was the last one outstanding.
      irq_o <= done_evt && fifo_empty && !push;
      // A new error in the clear cycle survives the clear.
      err_o <= (err_clr_i ? 3'b000 : err_o) | err_new;
    end
  end

  assign busy_o      = (state != ST_IDLE) || !fifo_empty;
  assign cmd_ready_o = !fifo_full;

endmodule

// File: tb/tb_fhe_op_scheduler.sv
// tb/tb_fhe_op_scheduler.sv - self-checking bench for fhe_op_scheduler
module tb_fhe_op_scheduler;

  localparam int TMO = 16;
  localparam int QD  = 4;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_n = 1'b0;
  logic        cmd_wr_i = 1'b0;
  logic [31:0] cmd_data_i = '0;
  logic        cmd_ready_o;
  logic        op_start_o;
  logic [1:0]  op_code_o;
  logic [8:0]  op_src0_o, op_src1_o, op_dst_o;
  logic        op_done_i = 1'b0;
  logic        op_abort_o;
  logic        busy_o;
  logic [2:0]  queue_count_o;
  logic [15:0] retired_count_o;
  logic [2:0]  err_o;
  logic        err_clr_i = 1'b0;
  logic        irq_o;

  fhe_op_scheduler #(
    .ADDR_WIDTH     (9),
    .QUEUE_DEPTH    (QD),
    .TIMEOUT_CYCLES (TMO),
    .CNT_WIDTH      (16)
  ) dut (
    .wb_clk_i        (wb_clk_i),
    .wb_rst_n        (wb_rst_n),
    .cmd_wr_i        (cmd_wr_i),
    .cmd_data_i      (cmd_data_i),
    .cmd_ready_o     (cmd_ready_o),
    .op_start_o      (op_start_o),
    .op_code_o       (op_code_o),
    .op_src0_o       (op_src0_o),
    .op_src1_o       (op_src1_o),
    .op_dst_o        (op_dst_o),
    .op_done_i       (op_done_i),
    .op_abort_o      (op_abort_o),
    .busy_o          (busy_o),
    .queue_count_o   (queue_count_o),
    .retired_count_o (retired_count_o),
    .err_o           (err_o),
    .err_clr_i       (err_clr_i),
    .irq_o           (irq_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: pending words, the op in flight and its phase
  // (0 none, 1 start cycle, 2 waiting), elapsed wait cycles.
  logic [31:0] mq[$];
  int          ph;
  int          mt;
  logic [31:0] mcur;
  logic [15:0] mret;
  logic [2:0]  merr;
  logic        mirq;

  logic        s_start, s_abort, s_irq, s_ready;
  int          s_count;
  int          cyc_no   = 0;
  int          irq_seen = 0;
  int          issued[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [1:0] op, input int s0, input int s1, input int dst);
    logic [31:0] w;
    w        = 32'h8000_0000;
    w[1:0]   = op;
    w[10:2]  = 9'(s0);
    w[19:11] = 9'(s1);
    w[28:20] = 9'(dst);
    return w;
  endfunction

  task automatic model_clear();
    mq.delete();
    ph = 0; mt = 0; mcur = '0; mret = '0; merr = '0; mirq = 1'b0;
  endtask

  // One clock cycle: drive inputs, check every output against the model
  // at the falling edge, then advance the model at the rising edge.
  task automatic cyc(input logic wr, input logic [31:0] d, input logic done, input logic clr);
    int   sz;
    logic pop, push, ovf, inv, comp, ab;
    cmd_wr_i = wr; cmd_data_i = d; op_done_i = done; err_clr_i = clr;
    @(negedge wb_clk_i);
    sz  = mq.size();
    pop = (ph == 0) && (sz > 0);
    ab  = (ph == 2) && !done && (mt == TMO - 1);
    s_start = op_start_o; s_abort = op_abort_o; s_irq = irq_o;
    s_ready = cmd_ready_o; s_count = int'(queue_count_o);
    chk("start",   32'(op_start_o),      32'(ph == 1));
    chk("abort",   32'(op_abort_o),      32'(ab));
    chk("count",   32'(queue_count_o),   32'(sz));
    chk("ready",   32'(cmd_ready_o),     32'(sz < QD));
    chk("busy",    32'(busy_o),          32'((ph != 0) || (sz > 0)));
    chk("retired", 32'(retired_count_o), 32'(mret));
    chk("err",     32'(err_o),           32'(merr));
    chk("irq",     32'(irq_o),           32'(mirq));
    chk("code",    32'(op_code_o),       32'(mcur[1:0]));
    chk("src0",    32'(op_src0_o),       32'(mcur[10:2]));
    chk("src1",    32'(op_src1_o),       32'(mcur[19:11]));
    chk("dst",     32'(op_dst_o),        32'(mcur[28:20]));
    cyc_no++;
    if (s_irq) irq_seen++;
    if (s_start) issued.push_back(int'(op_src0_o));
    @(posedge wb_clk_i);
    push = wr && d[31] && ((sz < QD) || pop);
    ovf  = wr && d[31] && (sz == QD) && !pop;
    inv  = wr && !d[31];
    comp = ((ph == 1) || (ph == 2)) && done;
    mirq = comp && (sz == 0) && !push;
    merr = (clr ? 3'b000 : merr) | {ab, inv, ovf};
    if (comp) mret = mret + 16'd1;
    case (ph)
      0: if (pop) begin mcur = mq.pop_front(); ph = 1; end
      1: begin mt = 0; ph = done ? 0 : 2; end
      2: if (done || ab) ph = 0; else mt++;
      default: ph = 0;
    endcase
    if (push) mq.push_back(d);
    #1;
  endtask

  // Reset asserted between edges: outputs must clear without a clock edge.
  task automatic do_reset();
    cmd_wr_i = 1'b0; cmd_data_i = '0; op_done_i = 1'b0; err_clr_i = 1'b0;
    wb_rst_n = 1'b0;
    @(negedge wb_clk_i);
    chk("rst_ready",   32'(cmd_ready_o),     32'd1);
    chk("rst_start",   32'(op_start_o),      32'd0);
    chk("rst_abort",   32'(op_abort_o),      32'd0);
    chk("rst_busy",    32'(busy_o),          32'd0);
    chk("rst_count",   32'(queue_count_o),   32'd0);
    chk("rst_retired", 32'(retired_count_o), 32'd0);
    chk("rst_err",     32'(err_o),           32'd0);
    chk("rst_irq",     32'(irq_o),           32'd0);
    chk("rst_fields",  {23'd0, op_code_o, op_src0_o | op_src1_o | op_dst_o}, 32'd0);
    model_clear();
    @(posedge wb_clk_i);
    #1;
    wb_rst_n = 1'b1;
  endtask

  task automatic idle_until_phase(input int target);
    int n;
    n = 0;
    while ((ph != target) && (n < 64)) begin
      cyc(1'b0, '0, 1'b0, 1'b0);
      n++;
    end
  endtask

  initial begin
    int n, start_at, irq_base;
    logic [31:0] w, w2;
    model_clear();
    @(posedge wb_clk_i);
    #1;
    do_reset();

    // Single add: start two cycles after the write, done five cycles later.
    w = mk(2'b10, 100, 50, 256);
    cyc(1'b1, w, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("add_no_early_start", 32'(s_start), 32'd0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("add_start_n2", 32'(s_start), 32'd1);
    chk("add_fields", {21'd0, op_code_o, op_src0_o}, {21'd0, 2'd2, 9'd100});
    chk("add_src1_dst", {14'd0, op_src1_o, op_dst_o}, {14'd0, 9'd50, 9'd256});
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("add_irq", 32'(s_irq), 32'd1);
    chk("add_retired", 32'(retired_count_o), 32'd1);
    chk("add_busy", 32'(busy_o), 32'd0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("add_irq_once", 32'(irq_seen), 32'd1);

    // Queue fill with the core stalled, sixth write overflows.
    issued.delete();
    irq_base = irq_seen;
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, mk(2'b10, 10 + k, 20 + k, 30 + k), 1'b0, 1'b0);
      if (k == 4) begin
        chk("fill_count3", 32'(s_count), 32'd3);
        chk("fill_ready1", 32'(s_ready), 32'd1);
      end
      if (k == 5) begin
        chk("fill_count4", 32'(s_count), 32'd4);
        chk("fill_ready0", 32'(s_ready), 32'd0);
      end
    end
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("fill_overflow", 32'(err_o), 32'b001);
    for (int k = 0; k < 5; k++) begin
      idle_until_phase(2);
      cyc(1'b0, '0, 1'b1, 1'b0);
    end
    cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("fill_issued_n", 32'(issued.size()), 32'd5);
    for (int k = 0; k < issued.size(); k++) chk("fill_order", 32'(issued[k]), 32'(10 + k));
    chk("fill_retired", 32'(retired_count_o), 32'd6);
    chk("fill_irq_once", 32'(irq_seen - irq_base), 32'd1);

    // Invalid word and error clear.
    cyc(1'b1, 32'h0000_0001, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("inv_count", 32'(queue_count_o), 32'd0);
    chk("inv_err", 32'(err_o), 32'b011);
    cyc(1'b0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("clr_err", 32'(err_o), 32'd0);

    // Timeout: abort sixteen cycles after start, next op issues normally.
    w  = mk(2'b11, 200, 201, 202);
    w2 = mk(2'b01, 300, 301, 302);
    cyc(1'b1, w, 1'b0, 1'b0);
    cyc(1'b1, w2, 1'b0, 1'b0);
    n = 0;
    do begin cyc(1'b0, '0, 1'b0, 1'b0); n++; end while (!s_start && n < 8);
    chk("tmo_start_seen", 32'(s_start), 32'd1);
    start_at = cyc_no;
    n = 0;
    do begin cyc(1'b0, '0, 1'b0, 1'b0); n++; end while (!s_abort && n < 40);
    chk("tmo_abort_seen", 32'(s_abort), 32'd1);
    chk("tmo_distance", 32'(cyc_no - start_at), 32'd16);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("tmo_err", 32'(err_o), 32'b100);
    chk("tmo_retired", 32'(retired_count_o), 32'd6);
    chk("tmo_no_irq", 32'(s_irq), 32'd0);
    n = 0;
    while (!s_start && n < 8) begin cyc(1'b0, '0, 1'b0, 1'b0); n++; end
    chk("tmo_next_start", 32'(s_start), 32'd1);
    chk("tmo_next_src0", 32'(op_src0_o), 32'd300);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("tmo_next_retired", 32'(retired_count_o), 32'd7);

    // Full queue, done in WAIT, push lands on the pop cycle.
    for (int k = 0; k < 5; k++) cyc(1'b1, mk(2'b00, 40 + k, 0, 0), 1'b0, 1'b0);
    idle_until_phase(2);
    chk("fp_full", 32'(queue_count_o), 32'd4);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b1, mk(2'b00, 45, 0, 0), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("fp_no_overflow", 32'(err_o), 32'd0);
    chk("fp_count", 32'(queue_count_o), 32'd4);
    for (int k = 0; k < 5; k++) begin
      idle_until_phase(2);
      cyc(1'b0, '0, 1'b1, 1'b0);
    end
    cyc(1'b0, '0, 1'b0, 1'b0);

    // Reset while waiting with two entries queued.
    for (int k = 0; k < 3; k++) cyc(1'b1, mk(2'b10, 60 + k, 0, 0), 1'b0, 1'b0);
    idle_until_phase(2);
    chk("rstw_queued", 32'(queue_count_o), 32'd2);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("rstw_no_start", 32'(s_start), 32'd0);
    end
    chk("rstw_retired", 32'(retired_count_o), 32'd0);
    cyc(1'b1, mk(2'b01, 70, 71, 72), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("rstw_new_start", 32'(s_start), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      logic        wr, done, clr;
      logic [31:0] d;
      wr    = ($urandom % 3) == 0;
      d     = $urandom;
      d[31] = ($urandom % 5) != 0;
      done  = (ph != 0) ? (($urandom % 8) == 0) : (($urandom % 16) == 0);
      clr   = ($urandom % 20) == 0;
      cyc(wr, d, done, clr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
